// File: rtl/mbox_req.sv
// EBOX-to-memory request sequencer: one reference at a time over a req/ack port,
// with read-pause-write support and a watchdog that turns lost acks into nxmErr.
module mbox_req #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        EBOX_REQ,
  input  logic [22:0] EBOX_VMA,
  input  logic        eboxRead,
  input  logic        eboxWrite,
  input  logic        eboxPSE,
  input  logic [35:0] cacheDataWrite,
  output logic        mboxRespIn,
  output logic [35:0] cacheDataRead,
  output logic        nxmErr,
  output logic        mboxBusy,
  output logic        memReq,
  output logic        memRead,
  output logic        memWrite,
  output logic [22:0] memAdr,
  output logic [35:0] memWrData,
  input  logic        memAck,
  input  logic [35:0] memRdData,
  input  logic        memErr
);

  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR       = 3'd2,
    RESP     = 3'd3,
    PSE_HOLD = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        rpw_q, rpw_d;
  logic [11:0] cnt_q, cnt_d;
  logic [22:0] adr_q, adr_d;
  logic [35:0] wdata_q, wdata_d;
  logic [35:0] rdata_q, rdata_d;
  logic        nxm_q, nxm_d;

  always_comb begin
    // NOTE: every next-state value takes its hold value first, so no path infers a latch.
    state_d = state_q;
    rpw_d   = rpw_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nxm_d   = nxm_q;

    unique case (state_q)
      IDLE: begin
        if (EBOX_REQ && (eboxRead || eboxWrite)) begin
          adr_d = EBOX_VMA;
          nxm_d = 1'b0;
          cnt_d = '0;
          if (eboxRead) begin
            state_d = RD;
            rpw_d   = eboxPSE;
          end else begin
            state_d = WR;
            wdata_d = cacheDataWrite;
          end
        end
      end

      RD, WR: begin
        if (memAck) begin
          state_d = RESP;
          if (memErr) nxm_d = 1'b1;
          if (state_q == RD) rdata_d = memErr ? '0 : memRdData;
        end else if (cnt_q == TMO_LAST) begin
          // Abandon the reference; a timed-out read returns zero.
          state_d = RESP;
          nxm_d   = 1'b1;
          if (state_q == RD) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      RESP: begin
        // nxm_q was cleared at acceptance, so here it reflects only this phase.
        if (rpw_q && !nxm_q) begin
          state_d = PSE_HOLD;
        end else begin
          state_d = IDLE;
          rpw_d   = 1'b0;
        end
      end

      PSE_HOLD: begin
        if (EBOX_REQ) begin
          state_d = WR;
          wdata_d = cacheDataWrite;
          rpw_d   = 1'b0;
          nxm_d   = 1'b0;
          cnt_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state_q <= IDLE;
      rpw_q   <= 1'b0;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rpw_q   <= rpw_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nxm_q   <= nxm_d;
    end
  end

  assign mboxRespIn    = (state_q == RESP);
  assign mboxBusy      = (state_q != IDLE);
  assign memReq        = (state_q == RD) || (state_q == WR);
  assign memRead       = (state_q == RD);
  assign memWrite      = (state_q == WR);
  assign memAdr        = adr_q;
  assign memWrData     = wdata_q;
  assign cacheDataRead = rdata_q;
  assign nxmErr        = nxm_q;

endmodule
